// File: rtl/fetch_op_queue_pkg.sv
// rtl/fetch_op_queue_pkg.sv - shared opcode encodings, entry layout and state type for the op queue
package fetch_op_queue_pkg;

  localparam logic [4:0] OP_NONE = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_JALR = 5'd3;

  typedef enum logic {
    ST_RUN,
    ST_JALR_WAIT
  } q_state_e;

  // 88-bit decoded instruction, op in the low bits
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] imm;
    logic        jalr;
    logic        use_imm;
    logic        ls;
    logic        branch;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [4:0]  op;
  } op_entry_t;

endpackage

// File: rtl/op_queue_mem.sv
// rtl/op_queue_mem.sv - reset-free entry array, one write port, one asynchronous read port
module op_queue_mem
  import fetch_op_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  op_entry_t        wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output op_entry_t        rd_data_o
);

  op_entry_t mem_q [DEPTH];

  // Capture the tail entry on an accepted push
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_op_queue.sv
// rtl/fetch_op_queue.sv - decoded-instruction FIFO feeding issue, with JALR stall and flush
module fetch_op_queue
  import fetch_op_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic        in_branch,
  input  logic        in_ls,
  input  logic        in_use_imm,
  input  logic        in_jalr,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_addr,
  output logic [4:0]  op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        branch_out,
  output logic        ls,
  output logic        use_imm,
  output logic        jalr,
  output logic [31:0] imm,
  output logic [31:0] addr,
  output logic        inst_valid,
  input  logic        launch_fail,
  input  logic        jalr_done
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  q_state_e         state_q, state_d;

  op_entry_t wr_entry;
  op_entry_t head_entry;
  logic      push;
  logic      pop;

  assign wr_entry = {in_addr, in_imm, in_jalr, in_use_imm, in_ls, in_branch,
                     in_rs2, in_rs1, in_rd, in_op};

  // Handshake terms; launch_fail only reaches pop, never the offered head
  assign push_ready = (count_q < FULL_CNT);
  assign inst_valid = rdy_in && (count_q != '0) && (state_q == ST_RUN);
  assign pop        = inst_valid && !launch_fail && !flush;
  assign push       = push_valid && push_ready && !flush && rdy_in;

  op_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i     (clk_in),
    .wr_en_i   (push),
    .wr_addr_i (tail_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (head_q),
    .rd_data_o (head_entry)
  );

  // Next pointers, occupancy and JALR stall state; flush overrides push/pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = ST_RUN;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      case (state_q)
        ST_RUN:       if (pop && head_entry.jalr) state_d = ST_JALR_WAIT;
        ST_JALR_WAIT: if (jalr_done) state_d = ST_RUN;
        default:      state_d = ST_RUN;
      endcase
    end
  end

  // Register update; rdy_in low freezes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_RUN;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign op         = inst_valid ? head_entry.op      : OP_NONE;
  assign rd         = inst_valid ? head_entry.rd      : '0;
  assign rs1        = inst_valid ? head_entry.rs1     : '0;
  assign rs2        = inst_valid ? head_entry.rs2     : '0;
  assign branch_out = inst_valid ? head_entry.branch  : 1'b0;
  assign ls         = inst_valid ? head_entry.ls      : 1'b0;
  assign use_imm    = inst_valid ? head_entry.use_imm : 1'b0;
  assign jalr       = inst_valid ? head_entry.jalr    : 1'b0;
  assign imm        = inst_valid ? head_entry.imm     : '0;
  assign addr       = inst_valid ? head_entry.addr    : '0;

endmodule

// File: tb/tb_fetch_op_queue.sv
// tb/tb_fetch_op_queue.sv - scoreboard bench for fetch_op_queue
module tb_fetch_op_queue;
  import fetch_op_queue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, push_valid, push_ready;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic        in_branch, in_ls, in_use_imm, in_jalr;
  logic [31:0] in_imm, in_addr;
  logic [4:0]  op, rd, rs1, rs2;
  logic        branch_out, ls, use_imm, jalr;
  logic [31:0] imm, addr;
  logic        inst_valid, launch_fail, jalr_done;

  fetch_op_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_branch(in_branch), .in_ls(in_ls), .in_use_imm(in_use_imm), .in_jalr(in_jalr),
    .in_imm(in_imm), .in_addr(in_addr),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .branch_out(branch_out), .ls(ls), .use_imm(use_imm), .jalr(jalr),
    .imm(imm), .addr(addr), .inst_valid(inst_valid),
    .launch_fail(launch_fail), .jalr_done(jalr_done)
  );

  always #5 clk_in = ~clk_in;

  op_entry_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Field pattern derived from the PC so every entry is distinguishable
  function automatic op_entry_t mk(input logic [31:0] a, input logic [4:0] o);
    op_entry_t e;
    e.addr    = a;
    e.imm     = ~a;
    e.jalr    = (o == OP_JALR);
    e.use_imm = (o == OP_ADDI);
    e.ls      = a[3];
    e.branch  = a[2];
    e.rs2     = a[8:4];
    e.rs1     = a[7:3];
    e.rd      = a[6:2];
    e.op      = o;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [87:0] got, input logic [87:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic nxt();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  task automatic set_push(input logic [31:0] a, input logic [4:0] o, input bit accept);
    op_entry_t e;
    e = mk(a, o);
    push_valid = 1'b1;
    {in_addr, in_imm, in_jalr, in_use_imm, in_ls, in_branch, in_rs2, in_rs1, in_rd, in_op} = e;
    if (accept) sb.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      nxt();
      k++;
    end
    chk("drain_timeout", 88'(sb.size() == 0), 88'(1));
  endtask

  // Monitor: every cycle the head is taken, compare it with the oldest expected entry
  always @(negedge clk_in) begin
    op_entry_t got, e;
    if (!rst_in && rdy_in && inst_valid && !launch_fail && !flush) begin
      got = {addr, imm, jalr, use_imm, ls, branch_out, rs2, rs1, rd, op};
      if (sb.size() == 0) begin
        chk("unexpected_issue", 88'(got.addr), 88'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("issue_entry", got, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; push_valid = 1'b0;
    launch_fail = 1'b0; jalr_done = 1'b0;
    {in_addr, in_imm, in_jalr, in_use_imm, in_ls, in_branch, in_rs2, in_rs1, in_rd, in_op} = '0;

    // Reset state
    mid();
    chk("rst_push_ready", 88'(push_ready), 88'(1));
    chk("rst_inst_valid", 88'(inst_valid), 88'(0));
    chk("rst_op", 88'(op), 88'(OP_NONE));
    chk("rst_addr", 88'(addr), 88'(0));
    nxt();
    rst_in = 1'b0;

    // Three ADDI, one-cycle latency, back-to-back issue
    set_push(32'h00, OP_ADDI, 1); mid(); chk("no_bypass", 88'(inst_valid), 88'(0)); nxt();
    set_push(32'h04, OP_ADDI, 1); mid(); chk("issue_latency", 88'(inst_valid), 88'(1)); nxt();
    set_push(32'h08, OP_ADDI, 1); mid(); chk("throughput_valid", 88'(inst_valid), 88'(1)); nxt();
    push_valid = 1'b0; mid(); nxt();
    mid();
    chk("empty_valid", 88'(inst_valid), 88'(0));
    chk("empty_op", 88'(op), 88'(OP_NONE));
    nxt();

    // Fill to 8 without pops, drop the 9th, then stream with wrap
    launch_fail = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_push(32'h100 + 32'(4*i), OP_ADD, 1);
      mid(); chk("fill_push_ready", 88'(push_ready), 88'(1)); nxt();
    end
    set_push(32'h1FC, OP_ADD, 0);
    mid();
    chk("full_push_ready", 88'(push_ready), 88'(0));
    chk("full_head", 88'(addr), 88'(32'h100));
    nxt();
    push_valid = 1'b0; launch_fail = 1'b0;
    mid(); chk("full_with_pop_ready", 88'(push_ready), 88'(0)); nxt();
    for (int i = 0; i < 8; i++) begin
      set_push(32'h180 + 32'(4*i), OP_ADD, 1);
      mid(); nxt();
    end
    push_valid = 1'b0;
    drain();
    mid(); chk("wrap_empty", 88'(inst_valid), 88'(0)); nxt();

    // Head held by launch_fail; jalr_done in RUN is ignored
    set_push(32'h10, OP_ADD, 1); mid(); nxt();
    push_valid = 1'b0; launch_fail = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jalr_done = (i == 1);
      mid();
      chk("stall_valid", 88'(inst_valid), 88'(1));
      chk("stall_addr", 88'(addr), 88'(32'h10));
      nxt();
    end
    jalr_done = 1'b0; launch_fail = 1'b0;
    mid(); chk("stall_release", 88'(inst_valid), 88'(1)); nxt();
    mid(); chk("stall_popped", 88'(inst_valid), 88'(0)); nxt();

    // JALR blocks issue until jalr_done
    set_push(32'h20, OP_JALR, 1); mid(); nxt();
    set_push(32'h24, OP_ADD, 1); mid(); chk("jalr_offered", 88'(jalr), 88'(1)); nxt();
    push_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid(); chk("jalr_wait_valid", 88'(inst_valid), 88'(0)); nxt();
    end
    jalr_done = 1'b1;
    mid(); chk("jalr_done_cycle", 88'(inst_valid), 88'(0)); nxt();
    jalr_done = 1'b0;
    mid();
    chk("resume_valid", 88'(inst_valid), 88'(1));
    chk("resume_addr", 88'(addr), 88'(32'h24));
    nxt();
    mid(); chk("after_jalr_empty", 88'(inst_valid), 88'(0)); nxt();

    // Flush at count 5 in JALR_WAIT with a simultaneous push
    set_push(32'h40, OP_JALR, 1); mid(); nxt();
    for (int i = 0; i < 5; i++) begin
      set_push(32'h44 + 32'(4*i), OP_ADD, 1); mid(); nxt();
    end
    set_push(32'h60, OP_ADD, 0);
    flush = 1'b1;
    sb.delete();
    mid(); chk("flush_cycle_valid", 88'(inst_valid), 88'(0)); nxt();
    flush = 1'b0; push_valid = 1'b0;
    mid();
    chk("post_flush_valid", 88'(inst_valid), 88'(0));
    chk("post_flush_ready", 88'(push_ready), 88'(1));
    nxt();
    set_push(32'h70, OP_ADD, 1); mid(); nxt();
    push_valid = 1'b0;
    mid();
    chk("post_flush_run", 88'(inst_valid), 88'(1));
    chk("post_flush_addr", 88'(addr), 88'(32'h70));
    nxt();

    // rdy_in low freezes state and blocks push
    launch_fail = 1'b1;
    set_push(32'h300, OP_ADD, 1); mid(); nxt();
    set_push(32'h304, OP_ADD, 1); mid(); nxt();
    rdy_in = 1'b0; launch_fail = 1'b0;
    set_push(32'h308, OP_ADD, 0);
    for (int i = 0; i < 4; i++) begin
      mid(); chk("pause_valid", 88'(inst_valid), 88'(0)); nxt();
    end
    rdy_in = 1'b1; push_valid = 1'b0;
    mid(); chk("pause_head0", 88'(addr), 88'(32'h300)); nxt();
    mid(); chk("pause_head1", 88'(addr), 88'(32'h304)); nxt();
    mid(); chk("no_paused_push", 88'(inst_valid), 88'(0)); nxt();

    // Asynchronous reset while in JALR_WAIT with an entry queued
    set_push(32'h400, OP_JALR, 1); mid(); nxt();
    set_push(32'h404, OP_ADD, 0); mid(); nxt();
    push_valid = 1'b0;
    mid();
    #2 rst_in = 1'b1;
    #1;
    sb.delete();
    chk("async_rst_valid", 88'(inst_valid), 88'(0));
    chk("async_rst_ready", 88'(push_ready), 88'(1));
    chk("async_rst_op", 88'(op), 88'(OP_NONE));
    chk("async_rst_imm", 88'(imm), 88'(0));
    nxt();
    rst_in = 1'b0;
    set_push(32'h500, OP_ADD, 1); mid(); nxt();
    push_valid = 1'b0;
    mid();
    chk("post_rst_run", 88'(inst_valid), 88'(1));
    chk("post_rst_addr", 88'(addr), 88'(32'h500));
    nxt();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
